// File: rtl/compiled_regex_pkg.sv
// Shared definitions for the a(b|c)*d regex matcher.
//   POS_W          - width of byte positions and start registers
//   CH_A..CH_D     - pattern bytes
//   nfa_state_e    - one-hot NFA state indices (S0, S1, SACC)
//   phase_e        - matcher phase (STREAM, DONE)
//   active_t       - one-hot active-state vector
//   starts_t       - per-state start-position registers
//   min_pos        - returns the smaller of two positions
package compiled_regex_pkg;

    localparam int unsigned POS_W      = 32;
    localparam int unsigned NUM_STATES = 3;

    localparam logic [7:0] CH_A = 8'h61;
    localparam logic [7:0] CH_B = 8'h62;
    localparam logic [7:0] CH_C = 8'h63;
    localparam logic [7:0] CH_D = 8'h64;

    typedef enum logic [1:0] {
        S0   = 2'd0,
        S1   = 2'd1,
        SACC = 2'd2
    } nfa_state_e;

    typedef enum logic {
        STREAM = 1'b0,
        DONE   = 1'b1
    } phase_e;

    typedef logic [NUM_STATES-1:0]            active_t;
    typedef logic [NUM_STATES-1:0][POS_W-1:0] starts_t;

    function automatic logic [POS_W-1:0] min_pos(input logic [POS_W-1:0] a,
                                                  input logic [POS_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/compiled_regex_nfa_step.sv
// Combinational single-byte step of the a(b|c)*d NFA.
//   i_active       - currently active states (one-hot per state)
//   i_start        - start register of each state
//   i_char         - byte being consumed
//   i_pos          - position of i_char in the stream
//   o_active       - active states after consuming i_char
//   o_start        - start registers after consuming i_char
//   o_accept       - SACC becomes active on this byte
//   o_accept_start - start position of the accepted match
module regex_nfa_step
    import compiled_regex_pkg::*;
(
    input  active_t          i_active,
    input  starts_t          i_start,
    input  logic [7:0]       i_char,
    input  logic [POS_W-1:0] i_pos,
    output active_t          o_active,
    output starts_t          o_start,
    output logic             o_accept,
    output logic [POS_W-1:0] o_accept_start
);

    logic w_from_s0;
    logic w_loop_s1;
    logic w_to_acc;
    logic w_unused;

    assign w_from_s0 = i_active[S0] && (i_char == CH_A);
    assign w_loop_s1 = i_active[S1] && ((i_char == CH_B) || (i_char == CH_C));
    assign w_to_acc  = i_active[S1] && (i_char == CH_D);

    // SACC is terminal: its own activity and start never feed a transition.
    assign w_unused = ^{i_active[SACC], i_start[SACC]};

    always_comb begin
        o_active = '0;
        o_start  = '0;

        // S0 is always active; its start register tracks the current
        // position, so it holds the candidate start for a new match.
        o_active[S0] = 1'b1;
        o_start[S0]  = i_pos + POS_W'(1);

        o_active[S1] = w_from_s0 | w_loop_s1;
        if (w_from_s0 && w_loop_s1) begin
            o_start[S1] = min_pos(i_start[S0], i_start[S1]);
        end else if (w_from_s0) begin
            o_start[S1] = i_start[S0];
        end else if (w_loop_s1) begin
            o_start[S1] = i_start[S1];
        end

        o_active[SACC] = w_to_acc;
        if (w_to_acc) begin
            o_start[SACC] = i_start[S1];
        end
    end

    assign o_accept       = o_active[SACC];
    assign o_accept_start = o_start[SACC];

endmodule

// File: rtl/compiled_regex.sv
// Streaming matcher for the fixed regex a(b|c)*d.
// Consumes one byte per clock until `last`, then reports the first
// (earliest-ending, leftmost-starting) match and freezes until reset.
//   clk      - clock, rising edge
//   reset    - synchronous active-low reset
//   rdy      - result valid, sticky until reset
//   char     - input byte, consumed each cycle while streaming
//   last     - end of stream; `char` ignored in that cycle
//   match    - pattern found (valid when rdy=1)
//   startPos - position of first byte of reported match
//   endPos   - position of last byte of reported match (inclusive)
module compiled_regex
    import compiled_regex_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    output logic             rdy,
    input  logic [7:0]       char,
    input  logic             last,
    output logic             match,
    output logic [POS_W-1:0] startPos,
    output logic [POS_W-1:0] endPos
);

    phase_e           r_phase;
    active_t          r_active;
    starts_t          r_start;
    logic [POS_W-1:0] r_pos;
    logic             r_rdy;
    logic             r_match;
    logic [POS_W-1:0] r_start_pos;
    logic [POS_W-1:0] r_end_pos;

    active_t          w_next_active;
    starts_t          w_next_start;
    logic             w_accept;
    logic [POS_W-1:0] w_accept_start;

    regex_nfa_step u_step (
        .i_active       (r_active),
        .i_start        (r_start),
        .i_char         (char),
        .i_pos          (r_pos),
        .o_active       (w_next_active),
        .o_start        (w_next_start),
        .o_accept       (w_accept),
        .o_accept_start (w_accept_start)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_phase      <= STREAM;
            r_active     <= '0;
            r_active[S0] <= 1'b1;
            r_start      <= '0;
            r_pos        <= '0;
            r_rdy        <= 1'b0;
            r_match      <= 1'b0;
            r_start_pos  <= '0;
            r_end_pos    <= '0;
        end else begin
            case (r_phase)
                STREAM: begin
                    if (last) begin
                        r_phase <= DONE;
                        r_rdy   <= 1'b1;
                    end else begin
                        r_active <= w_next_active;
                        r_start  <= w_next_start;
                        r_pos    <= r_pos + POS_W'(1);
                        // Only the first accept is recorded.
                        if (w_accept && !r_match) begin
                            r_match     <= 1'b1;
                            r_start_pos <= w_accept_start;
                            r_end_pos   <= r_pos;
                        end
                    end
                end
                DONE: begin
                    // Result frozen until reset.
                end
                default: begin
                    r_phase <= STREAM;
                end
            endcase
        end
    end

    assign rdy      = r_rdy;
    assign match    = r_match;
    assign startPos = r_start_pos;
    assign endPos   = r_end_pos;

endmodule

// File: tb/tb_compiled_regex.sv
module tb_compiled_regex;

    logic        clk;
    logic        reset;
    logic        rdy;
    logic [7:0]  char;
    logic        last;
    logic        match;
    logic [31:0] startPos;
    logic [31:0] endPos;

    int unsigned n_cmp;
    int unsigned n_bad;

    byte unsigned stim_q[$];

    compiled_regex dut (
        .clk      (clk),
        .reset    (reset),
        .rdy      (rdy),
        .char     (char),
        .last     (last),
        .match    (match),
        .startPos (startPos),
        .endPos   (endPos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_str(input string s);
        stim_q.delete();
        for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        last  = 1'b0;
        char  = 8'h00;
        tick();
        reset = 1'b1;
    endtask

    task automatic stream_bytes();
        for (int i = 0; i < stim_q.size(); i++) begin
            char = stim_q[i];
            last = 1'b0;
            tick();
        end
    endtask

    task automatic end_stream();
        last = 1'b1;
        char = 8'h64;
        tick();
        last = 1'b0;
    endtask

    // Reference: scan ends left to right; for the first end byte 'd' that
    // closes a valid a(b|c)*d span, take the leftmost valid start.
    function automatic void ref_model(output bit found, output int unsigned s_o,
                                      output int unsigned e_o);
        bit ok;
        found = 0;
        s_o   = 0;
        e_o   = 0;
        for (int e = 0; e < stim_q.size() && !found; e++) begin
            if (stim_q[e] == 8'h64) begin
                for (int s = 0; s < e && !found; s++) begin
                    ok = (stim_q[s] == 8'h61);
                    for (int k = s + 1; k < e; k++)
                        if (stim_q[k] != 8'h62 && stim_q[k] != 8'h63) ok = 0;
                    if (ok) begin
                        found = 1;
                        s_o   = s;
                        e_o   = e;
                    end
                end
            end
        end
    endfunction

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({rdy, match, startPos, endPos} !== 66'd0) begin
            n_bad++;
            $display("FAIL reset_state: got rdy=%0b match=%0b start=%0d end=%0d, want all 0",
                     rdy, match, startPos, endPos);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        load_str("xxabcd");
        stream_bytes();
        n_cmp++;
        if (rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL rdy_while_streaming: got %0b want 0", rdy);
        end
        end_stream();
        n_cmp++;
        if ({rdy, match, startPos, endPos} !== {1'b1, 1'b1, 32'd2, 32'd5}) begin
            n_bad++;
            $display("FAIL xxabcd: got rdy=%0b match=%0b start=%0d end=%0d, want 1 1 2 5",
                     rdy, match, startPos, endPos);
        end

        apply_reset();
        load_str("abxd");
        stream_bytes();
        end_stream();
        n_cmp++;
        if ({rdy, match} !== 2'b10) begin
            n_bad++;
            $display("FAIL abxd: got rdy=%0b match=%0b, want rdy=1 match=0", rdy, match);
        end
    endtask

    task automatic test_overlap();
        apply_reset();
        load_str("aabd");
        stream_bytes();
        end_stream();
        n_cmp++;
        if ({rdy, match, startPos, endPos} !== {1'b1, 1'b1, 32'd1, 32'd3}) begin
            n_bad++;
            $display("FAIL aabd: got rdy=%0b match=%0b start=%0d end=%0d, want 1 1 1 3",
                     rdy, match, startPos, endPos);
        end

        apply_reset();
        load_str("adabd");
        stream_bytes();
        end_stream();
        n_cmp++;
        if ({rdy, match, startPos, endPos} !== {1'b1, 1'b1, 32'd0, 32'd1}) begin
            n_bad++;
            $display("FAIL adabd: got rdy=%0b match=%0b start=%0d end=%0d, want 1 1 0 1",
                     rdy, match, startPos, endPos);
        end
    endtask

    task automatic test_empty();
        apply_reset();
        end_stream();
        n_cmp++;
        if ({rdy, match, startPos, endPos} !== {1'b1, 1'b0, 32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL empty: got rdy=%0b match=%0b start=%0d end=%0d, want 1 0 0 0",
                     rdy, match, startPos, endPos);
        end
        load_str("ad");
        stream_bytes();
        end_stream();
        n_cmp++;
        if ({rdy, match, startPos, endPos} !== {1'b1, 1'b0, 32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL empty_then_ad: got rdy=%0b match=%0b start=%0d end=%0d, want 1 0 0 0",
                     rdy, match, startPos, endPos);
        end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        load_str("ab");
        stream_bytes();
        apply_reset();
        load_str("d");
        stream_bytes();
        end_stream();
        n_cmp++;
        if ({rdy, match} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_mid_stream: got rdy=%0b match=%0b, want rdy=1 match=0",
                     rdy, match);
        end

        reset = 1'b0;
        last  = 1'b1;
        tick();
        reset = 1'b1;
        last  = 1'b0;
        n_cmp++;
        if ({rdy, match, startPos, endPos} !== 66'd0) begin
            n_bad++;
            $display("FAIL reset_with_last: got rdy=%0b match=%0b start=%0d end=%0d, want all 0",
                     rdy, match, startPos, endPos);
        end
    endtask

    task automatic test_hold();
        bit bad;
        apply_reset();
        load_str("ad");
        stream_bytes();
        end_stream();
        n_cmp++;
        if ({rdy, match, startPos, endPos} !== {1'b1, 1'b1, 32'd0, 32'd1}) begin
            n_bad++;
            $display("FAIL ad: got rdy=%0b match=%0b start=%0d end=%0d, want 1 1 0 1",
                     rdy, match, startPos, endPos);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            char = (i % 2 == 0) ? 8'h61 : 8'h64;
            last = (i == 5);
            tick();
            if ({rdy, match, startPos, endPos} !== {1'b1, 1'b1, 32'd0, 32'd1}) bad = 1;
        end
        last = 1'b0;
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL hold_after_rdy: got rdy=%0b match=%0b start=%0d end=%0d, want 1 1 0 1",
                     rdy, match, startPos, endPos);
        end
    endtask

    task automatic test_random();
        bit          exp_found;
        int unsigned exp_s;
        int unsigned exp_e;
        int unsigned len;
        for (int t = 0; t < 40; t++) begin
            stim_q.delete();
            len = $urandom_range(0, 20);
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 5))
                    0, 1:    stim_q.push_back(8'h61);
                    2:       stim_q.push_back(8'h62);
                    3:       stim_q.push_back(8'h63);
                    4:       stim_q.push_back(8'h64);
                    default: stim_q.push_back(8'($urandom_range(0, 255)));
                endcase
            end
            ref_model(exp_found, exp_s, exp_e);
            apply_reset();
            stream_bytes();
            end_stream();
            n_cmp++;
            if ({rdy, match, startPos, endPos} !== {1'b1, exp_found, exp_s, exp_e}) begin
                n_bad++;
                $display("FAIL random_%0d: got rdy=%0b match=%0b start=%0d end=%0d, want 1 %0b %0d %0d",
                         t, rdy, match, startPos, endPos, exp_found, exp_s, exp_e);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        last  = 1'b0;
        char  = 8'h00;
        test_reset();
        test_basic();
        test_overlap();
        test_empty();
        test_reset_midstream();
        test_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
